serializer_wide_narrow: RTL



---
 rtl/serializer_wide_narrow.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/serializer_wide_narrow.sv
// serializer_wide_narrow: buffers IN_W-bit words in a DEPTH-word FIFO and
// streams them out as IN_W/OUT_W chunks of OUT_W bits on consumer request.
//
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   strobe_in        write strobe for input_data (dropped when full)
//   input_data       IN_W-bit input word
//   req_data         consumer request for one chunk
//   ready            a loaded word has chunks available (registered)
//   strobe_out       data_out valid, one cycle per chunk
//   data_out         OUT_W-bit chunk, holds its last value
//   data_end         marks the last chunk of a word (with strobe_out)
//   full             FIFO holds DEPTH words
//   overflow         one-cycle pulse after a dropped write
//
// Optional build macro SER_MSB_FIRST_EN: emit chunks most-significant
// first. Undefined (default): least-significant chunk first.

module serializer_wide_narrow #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_in,
  input  logic [IN_W-1:0]  input_data,
  input  logic             req_data,
  output logic             ready,
  output logic             data_end,
  output logic             strobe_out,
  output logic [OUT_W-1:0] data_out,
  output logic             full,
  output logic             overflow
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] LAST_C  = CW'(RATIO - 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [IN_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     fcnt_q;
  logic [AW:0]     fcnt_d;
  logic            full_q;
  logic            ovf_q;

  // Holding register and output side
  state_t          state_q;
  logic [IN_W-1:0] hold_q;
  logic [CW-1:0]   cnt_q;
  logic            strobe_q;
  logic            end_q;
  logic [OUT_W-1:0] dout_q;

  logic             empty;
  logic             last;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] chunk_w [RATIO];
  logic [OUT_W-1:0] chunk;

  assign empty = (fcnt_q == '0);
  assign last  = (cnt_q == LAST_C);

  // A write is refused while full even if a pop frees a slot
  // at the same edge; full is the registered flag.
  assign push = strobe_in & ~full_q;

  // Pop either to fill an idle holding register, or to chain the
  // next word right behind the last chunk of the current one.
  assign pop = ~empty &
               ((state_q == IDLE) |
                (req_data & last));

  always_comb begin
    fcnt_d = fcnt_q;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
    for (int k = 0; k < RATIO; k++) begin
`ifdef SER_MSB_FIRST_EN
      chunk_w[k] = hold_q[IN_W-1-k*OUT_W -: OUT_W];
`else
      chunk_w[k] = hold_q[k*OUT_W +: OUT_W];
`endif
    end
  end

  assign chunk = chunk_w[cnt_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= input_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      fcnt_q <= fcnt_d;
      full_q <= (fcnt_d == DEPTH_C);
      ovf_q  <= strobe_in & full_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      end_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      strobe_q <= 1'b0;
      end_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            hold_q  <= mem_q[rptr_q];
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (req_data) begin
            strobe_q <= 1'b1;
            dout_q   <= chunk;
            end_q    <= last;
            if (!last) begin
              cnt_q <= cnt_q + CW'(1);
            end else if (!empty) begin
              hold_q <= mem_q[rptr_q];
              cnt_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = (state_q == SHIFT);
  assign strobe_out = strobe_q;
  assign data_end   = end_q;
  assign data_out   = dout_q;
  assign full       = full_q;
  assign overflow   = ovf_q;

endmodule
